// File: rtl/mem_ctrl_if.sv
// Request/response bundle between the pipeline requesters, mem_ctrl and the byte-wide RAM.
// The slave modport is the controller's view; master is the requester/RAM side.
interface mem_ctrl_if #(
   parameter int unsigned ADDR_W = 17
) ();
   logic              if_r_enable_i;
   logic [31:0]       if_addr_i;
   logic [31:0]       if_data_o;
   logic              if_busy_o;
   logic              if_done_o;

   logic              mem_r_enable_i;
   logic              mem_w_enable_i;
   logic [31:0]       mem_addr_i;
   logic [31:0]       mem_wdata_i;
   logic [3:0]        mem_wmask_i;
   logic [31:0]       mem_rdata_o;
   logic              mem_busy_o;
   logic              mem_done_o;

   logic [ADDR_W-1:0] ram_addr_o;
   logic [7:0]        ram_dout_o;
   logic              ram_wr_o;
   logic [7:0]        ram_din_i;

   modport slave (
      input  if_r_enable_i, if_addr_i,
      output if_data_o, if_busy_o, if_done_o,
      input  mem_r_enable_i, mem_w_enable_i, mem_addr_i, mem_wdata_i, mem_wmask_i,
      output mem_rdata_o, mem_busy_o, mem_done_o,
      output ram_addr_o, ram_dout_o, ram_wr_o,
      input  ram_din_i
   );

   modport master (
      output if_r_enable_i, if_addr_i,
      input  if_data_o, if_busy_o, if_done_o,
      output mem_r_enable_i, mem_w_enable_i, mem_addr_i, mem_wdata_i, mem_wmask_i,
      input  mem_rdata_o, mem_busy_o, mem_done_o,
      input  ram_addr_o, ram_dout_o, ram_wr_o,
      output ram_din_i
   );
endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: 32-bit fetches and loads/stores over one byte-wide RAM port.
// Data port wins arbitration; each transaction runs accept -> 4 byte cycles -> drain -> DONE.
module mem_ctrl #(
   parameter int unsigned ADDR_W = 17
) (
   input logic       clk,
   input logic       rst,
   mem_ctrl_if.slave bus
);
   typedef enum logic [2:0] {StIdle, StIfRd, StMemRd, StMemWr, StDone} state_e;

   state_e            state_q, state_d;
   logic [1:0]        k_q, k_d;
   logic [1:0]        drain_q, drain_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wmask_q, wmask_d;
   logic [23:0]       rbuf_q, rbuf_d;
   logic [31:0]       if_data_q, if_data_d;
   logic [31:0]       mem_rdata_q, mem_rdata_d;
   logic              if_done_q, if_done_d;
   logic              mem_done_q, mem_done_d;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
   logic [7:0]        ram_dout_q, ram_dout_d;
   logic              ram_wr_q, ram_wr_d;
   logic              is_rd;
   logic              busy;
   logic [1:0]        cap_idx;

   // Requester address bits above the RAM width are don't-care.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.if_addr_i[31:ADDR_W], bus.mem_addr_i[31:ADDR_W]};

   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      drain_d     = drain_q;
      base_d      = base_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;
      rbuf_d      = rbuf_q;
      if_data_d   = if_data_q;
      mem_rdata_d = mem_rdata_q;
      if_done_d   = 1'b0;
      mem_done_d  = 1'b0;
      ram_addr_d  = ram_addr_q;
      ram_dout_d  = ram_dout_q;
      ram_wr_d    = 1'b0;
      is_rd       = (state_q == StIfRd) || (state_q == StMemRd);
      cap_idx     = k_q - 2'd1;

      // Read data lags its address by one cycle, so capture trails the issue counter.
      if (is_rd && ((k_q != 2'd0) || (drain_q != 2'd0))) begin
         case (cap_idx)
            2'd0:    rbuf_d[7:0]   = bus.ram_din_i;
            2'd1:    rbuf_d[15:8]  = bus.ram_din_i;
            2'd2:    rbuf_d[23:16] = bus.ram_din_i;
            default: ;
         endcase
      end

      unique case (state_q)
         StIdle: begin
            k_d     = 2'd0;
            drain_d = 2'd0;
            if (bus.mem_w_enable_i) begin
               state_d = StMemWr;
               base_d  = bus.mem_addr_i[ADDR_W-1:0];
               wdata_d = bus.mem_wdata_i;
               wmask_d = bus.mem_wmask_i;
            end else if (bus.mem_r_enable_i) begin
               state_d = StMemRd;
               base_d  = bus.mem_addr_i[ADDR_W-1:0];
            end else if (bus.if_r_enable_i) begin
               state_d = StIfRd;
               base_d  = bus.if_addr_i[ADDR_W-1:0];
            end
         end
         StIfRd, StMemRd, StMemWr: begin
            if (drain_q == 2'd0) begin
               ram_addr_d = base_q + ADDR_W'(k_q);
               if (state_q == StMemWr) begin
                  ram_wr_d   = wmask_q[k_q];
                  ram_dout_d = wdata_q[8*k_q +: 8];
               end
               k_d = k_q + 2'd1;
               if (k_q == 2'd3) begin
                  drain_d = 2'd1;
               end
            end else begin
               state_d = StDone;
               drain_d = 2'd0;
               if (state_q == StIfRd) begin
                  if_data_d = {bus.ram_din_i, rbuf_q};
                  if_done_d = 1'b1;
               end else if (state_q == StMemRd) begin
                  mem_rdata_d = {bus.ram_din_i, rbuf_q};
                  mem_done_d  = 1'b1;
               end else begin
                  mem_done_d = 1'b1;
               end
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         k_q         <= '0;
         drain_q     <= '0;
         base_q      <= '0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         rbuf_q      <= '0;
         if_data_q   <= '0;
         mem_rdata_q <= '0;
         if_done_q   <= 1'b0;
         mem_done_q  <= 1'b0;
         ram_addr_q  <= '0;
         ram_dout_q  <= '0;
         ram_wr_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         drain_q     <= drain_d;
         base_q      <= base_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
         rbuf_q      <= rbuf_d;
         if_data_q   <= if_data_d;
         mem_rdata_q <= mem_rdata_d;
         if_done_q   <= if_done_d;
         mem_done_q  <= mem_done_d;
         ram_addr_q  <= ram_addr_d;
         ram_dout_q  <= ram_dout_d;
         ram_wr_q    <= ram_wr_d;
      end
   end

   assign busy = (state_q == StIfRd) || (state_q == StMemRd) || (state_q == StMemWr);

   assign bus.if_data_o   = if_data_q;
   assign bus.if_busy_o   = busy;
   assign bus.if_done_o   = if_done_q;
   assign bus.mem_rdata_o = mem_rdata_q;
   assign bus.mem_busy_o  = busy;
   assign bus.mem_done_o  = mem_done_q;
   assign bus.ram_addr_o  = ram_addr_q;
   assign bus.ram_dout_o  = ram_dout_q;
   assign bus.ram_wr_o    = ram_wr_q;
endmodule
